// File: rtl/fetch_pkg.sv
// Shared fetch-sequencer types: FSM state enum and its externally visible encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_FETCH  = 2'd1;
    localparam logic [1:0] ENC_STEP   = 2'd2;
    localparam logic [1:0] ENC_HALTED = 2'd3;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the program counter that addresses the
// combinational instruction memory and registers the fetched word for the decoder.
//
// state  | meaning
// IDLE   | no fetching; waits for run (continuous) or step (single fetch)
// FETCH  | one load per cycle unless stalled; leaves on run=0
// STEP   | single load regardless of stall, then back to IDLE
// HALTED | decoder saw HALT; frozen until run and step are both low
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                       COUNTER_WIDTH = 8,
    parameter int                       WIDTH         = 16,
    parameter logic [COUNTER_WIDTH-1:0] RESET_VECTOR  = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     step,
    input  logic                     stall,
    input  logic                     jump_valid,
    input  logic [COUNTER_WIDTH-1:0] jump_target,
    input  logic                     halt,
    input  logic [WIDTH-1:0]         instruction_in,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic [WIDTH-1:0]         instruction,
    output logic                     instruction_valid,
    output logic [1:0]               state,
    output logic                     wrapped
);

    localparam logic [COUNTER_WIDTH-1:0] PC_ONE = COUNTER_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0]         instr_q, instr_d;
    logic                     valid_q, valid_d;
    logic                     wrapped_q, wrapped_d;
    logic                     load;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= RESET_VECTOR;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Next state and datapath: halt beats jump beats the per-state action.
    // Halt/jump only count when the decoder is looking at a live word.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        wrapped_d = wrapped_q;
        load      = 1'b0;

        if (valid_q && halt) begin
            state_d = HALTED;
            valid_d = 1'b0;
        end else if (valid_q && jump_valid) begin
            // Redirect squashes the wrong-path word, leaving one bubble.
            count_d = jump_target;
            valid_d = 1'b0;
            if (state_q == STEP) state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    if (run)       state_d = FETCH;
                    else if (step) state_d = STEP;
                end
                FETCH: begin
                    if (!stall) begin
                        if (!run) begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
                STEP: begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
                HALTED: begin
                    // Requiring run low forces a deliberate re-arm after HALT.
                    if (!run && !step) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Memory data is for the current count, so capture and advance together.
        if (load) begin
            instr_d = instruction_in;
            valid_d = 1'b1;
            count_d = count_q + PC_ONE;
            if (&count_q) wrapped_d = 1'b1;
        end
    end

    assign count             = count_q;
    assign instruction       = instr_q;
    assign instruction_valid = valid_q;
    assign state             = state_q;
    assign wrapped           = wrapped_q;

endmodule
